// File: rtl/bcd_display_scan_if.sv
// Signal bundle between the binary-to-BCD converter (and its observers) and
// the multiplexed 7-segment display scanner.
//   bcd_in   : packed BCD result, nibble 0 (bits 3:0) least significant
//   finished : converter done flag (level; may stay high for many cycles)
//   seg      : segments {g,f,e,d,c,b,a}, active-low
//   an       : anode enables, active-low
//   valid    : high once at least one result has been captured
// master drives the converter side; slave is the display scanner.
interface bcd_display_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    finished;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    valid;

  modport master (
    output bcd_in, finished,
    input  seg, an, valid
  );

  modport slave (
    input  bcd_in, finished,
    output seg, an, valid
  );
endinterface

// File: rtl/bcd_display_scan.sv
// Multiplexed common-anode 7-segment display driver for a packed BCD result.
// Captures bcd_in on the rising edge of finished, then scans the digits one at
// a time: each digit is driven for REFRESH_DIV cycles followed by GUARD_CYCLES
// cycles with every anode off to suppress ghosting. Leading zeros above digit 0
// are blanked; nibbles above 9 show an "E" glyph.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : bcd_display_scan_if.slave (bcd_in, finished in; seg, an, valid out)
module bcd_display_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  bcd_display_scan_if.slave      bus
);

  localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  logic [1:0]              state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [4*NUM_DIGITS-1:0] disp_reg;
  logic                    finished_d_reg;
  logic                    valid_reg;
  logic [6:0]              seg_reg;
  logic [NUM_DIGITS-1:0]   an_reg;

  logic                    capture;
  logic [6:0]              glyph [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   an_drive;

  assign capture = bus.finished && !finished_d_reg;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0000110;
    endcase
  endfunction

  // Per-digit glyph. A digit above 0 is blanked only when it and every higher
  // nibble are zero; comparing the whole upper slice keeps any non-zero
  // (including >9) higher nibble from blanking the digits below it.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign glyph[gi] = decode(disp_reg[3:0]);
      end else begin : g_upper
        logic upper_zero;
        assign upper_zero = (disp_reg[4*NUM_DIGITS-1:4*gi] == '0);
        assign glyph[gi]  = upper_zero ? SEG_BLANK : decode(disp_reg[4*gi +: 4]);
      end
      assign an_drive[gi] = (idx_reg != IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (capture) begin
          state_next = S_DRIVE;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end
      S_DRIVE: begin
        if (cnt_reg == CNT_W'(REFRESH_DIV - 1)) begin
          state_next = S_GUARD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_GUARD: begin
        if (cnt_reg == CNT_W'(GUARD_CYCLES - 1)) begin
          state_next = S_DRIVE;
          cnt_next   = '0;
          idx_next   = (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      disp_reg       <= '0;
      finished_d_reg <= 1'b0;
      valid_reg      <= 1'b0;
      seg_reg        <= SEG_BLANK;
      an_reg         <= '1;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      finished_d_reg <= bus.finished;
      if (capture) begin
        disp_reg  <= bus.bcd_in;
        valid_reg <= 1'b1;
      end
      // Outputs follow the current state/index one cycle later, together.
      if (state_reg == S_DRIVE) begin
        seg_reg <= glyph[idx_reg];
        an_reg  <= an_drive;
      end else begin
        seg_reg <= SEG_BLANK;
        an_reg  <= '1;
      end
    end
  end

  assign bus.seg   = seg_reg;
  assign bus.an    = an_reg;
  assign bus.valid = valid_reg;

endmodule
